// File: rtl/sram_port_arbiter.sv
// Round-robin byte-access arbiter/sequencer for port 0 of a 32x512 SRAM macro; grant 1 cycle after sample,
// read data WAIT_CYCLES+2 cycles after sample; a loser simply keeps req high until it is granted.
module sram_port_arbiter #(
  parameter int WAIT_CYCLES = 1  // 1..4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic [10:0] a_addr,
  input  logic [10:0] b_addr,
  input  logic [7:0]  a_wdata,
  input  logic [7:0]  b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        ram_clk0,
  output logic        ram_csb0,
  output logic        ram_web0,
  output logic [3:0]  ram_wmask0,
  output logic [8:0]  ram_addr0,
  output logic [31:0] ram_din0,
  input  logic [31:0] ram_dout0
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [1:0] CNT_LAST = 2'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_b;
  logic        owner_b;
  logic        we_q;
  logic [10:0] addr_q;
  logic [1:0]  cnt;
  logic        grant_now;
  logic        win_b;
  logic        cap_now;
  logic        sel_we;
  logic [10:0] sel_addr;
  logic [7:0]  sel_wdata;

  assign ram_clk0 = clk;
  assign busy     = (state != IDLE);
  assign a_gnt    = (state == ISSUE) && !owner_b;
  assign b_gnt    = (state == ISSUE) && owner_b;

  assign sel_we    = win_b ? b_we    : a_we;
  assign sel_addr  = win_b ? b_addr  : a_addr;
  assign sel_wdata = win_b ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    win_b     = 1'b0;
    cap_now   = 1'b0;
    case (state)
      IDLE: begin
        if (ena && (a_req || b_req)) begin
          grant_now = 1'b1;
          // B wins when alone, or on a tie when A was served last
          win_b     = b_req && (!a_req || !last_b);
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = we_q ? IDLE : WAIT;
      WAIT: begin
        if (cnt == CNT_LAST) begin
          cap_now   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b     <= 1'b1;
      owner_b    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      cnt        <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      rdata      <= '0;
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0  <= '0;
      ram_din0   <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (grant_now) begin
        owner_b   <= win_b;
        last_b    <= win_b;
        we_q      <= sel_we;
        addr_q    <= sel_addr;
        ram_csb0  <= 1'b0;
        ram_web0  <= ~sel_we;
        ram_addr0 <= sel_addr[10:2];
        if (sel_we) begin
          ram_wmask0 <= 4'b0001 << sel_addr[1:0];
          ram_din0   <= {4{sel_wdata}};
        end else begin
          ram_wmask0 <= '0;
        end
      end
      if (state == ISSUE) begin
        ram_csb0   <= 1'b1;
        ram_web0   <= 1'b1;
        ram_wmask0 <= '0;
        cnt        <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + 2'd1;
        if (cap_now) begin
          rdata    <= ram_dout0[{addr_q[1:0], 3'b000} +: 8];
          a_rvalid <= !owner_b;
          b_rvalid <= owner_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, byte reference memory and per-requester read scoreboards.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [10:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, busy, ram_clk0, ram_csb0, ram_web0;
  logic [7:0]  rdata;
  logic [3:0]  ram_wmask0;
  logic [8:0]  ram_addr0;
  logic [31:0] ram_din0;
  logic [31:0] ram_dout0 = '0;

  // second instance with a longer wait, its read word driven directly by the bench
  logic        c_req = 1'b0, c_we = 1'b0, c_zero = 1'b0;
  logic [10:0] c_addr = '0, c_zaddr = '0;
  logic [7:0]  c_zdat = '0;
  logic [31:0] c_dout = '0;
  logic        c_gnt, c_bgnt, c_rvalid, c_brvalid, c_busy, c_clk0, c_csb0, c_web0;
  logic [7:0]  c_rdata;
  logic [3:0]  c_wmask0;
  logic [8:0]  c_addr0;
  logic [31:0] c_din0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [0:511];
  logic [7:0]  ref_mem [0:2047];
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  bit          gnt_log[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .busy(busy), .ram_clk0(ram_clk0), .ram_csb0(ram_csb0),
    .ram_web0(ram_web0), .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0),
    .ram_din0(ram_din0), .ram_dout0(ram_dout0)
  );

  sram_port_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1),
    .a_req(c_req), .b_req(c_zero), .a_we(c_we), .b_we(c_zero),
    .a_addr(c_addr), .b_addr(c_zaddr), .a_wdata(c_zdat), .b_wdata(c_zdat),
    .a_gnt(c_gnt), .b_gnt(c_bgnt), .a_rvalid(c_rvalid), .b_rvalid(c_brvalid),
    .rdata(c_rdata), .busy(c_busy), .ram_clk0(c_clk0), .ram_csb0(c_csb0),
    .ram_web0(c_web0), .ram_wmask0(c_wmask0), .ram_addr0(c_addr0),
    .ram_din0(c_din0), .ram_dout0(c_dout)
  );

  // macro model: masked write or read on the rising edge while selected
  always @(posedge clk) begin
    if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int i = 0; i < 4; i++)
          if (ram_wmask0[i]) mem[ram_addr0][8*i +: 8] <= ram_din0[8*i +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  // read scoreboard and grant log
  always @(negedge clk) begin
    if (a_rvalid) begin
      tests++;
      if (exp_a.size() == 0) begin
        fails++; $display("FAIL a_rvalid_unexpected: got rvalid with rdata %h, required no rvalid", rdata);
      end else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        if (rdata !== e) begin fails++; $display("FAIL a_rdata: got %h required %h", rdata, e); end
      end
    end
    if (b_rvalid) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++; $display("FAIL b_rvalid_unexpected: got rvalid with rdata %h, required no rvalid", rdata);
      end else begin
        logic [7:0] e;
        e = exp_b.pop_front();
        if (rdata !== e) begin fails++; $display("FAIL b_rdata: got %h required %h", rdata, e); end
      end
    end
    if (a_gnt) gnt_log.push_back(1'b0);
    if (b_gnt) gnt_log.push_back(1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // one requester transaction: raise req, hold until gnt, drop on the following edge
  task automatic access(input bit is_b, input bit we, input logic [10:0] addr, input logic [7:0] wd);
    int n;
    if (is_b) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    if (we) ref_mem[addr] = wd;
    else if (is_b) exp_b.push_back(ref_mem[addr]);
    else exp_a.push_back(ref_mem[addr]);
    n = 0;
    do begin @(negedge clk); n++; end while (!(is_b ? b_gnt : a_gnt) && n < 50);
    tests++;
    if (n >= 50) begin fails++; $display("FAIL gnt_timeout: requester %0d got no gnt in %0d cycles, required a gnt", is_b, n); end
    @(posedge clk); #1;
    if (is_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while ((busy || exp_a.size() != 0 || exp_b.size() != 0) && n < 40);
    tests++;
    if (n >= 40) begin
      fails++;
      $display("FAIL drain: busy=%b pending a=%0d b=%0d, required idle with no pending reads", busy, exp_a.size(), exp_b.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0, a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy}
        !== {1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: csb=%b web=%b wmask=%h addr=%h din=%h gnt=%b%b rvalid=%b%b rdata=%h busy=%b, required 1 1 0 0 0 00 00 00 0",
               ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0, a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy);
    end
    tests++;
    if ({c_csb0, c_busy, c_rvalid} !== 3'b100) begin
      fails++; $display("FAIL reset_values_w3: csb/busy/rvalid=%b required 100", {c_csb0, c_busy, c_rvalid});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    a_we = 1'b1; a_addr = 11'h005; a_wdata = 8'hA5; a_req = 1'b1; ref_mem[5] = 8'hA5;
    @(negedge clk);
    tests++;
    if (a_gnt !== 1'b0) begin fails++; $display("FAIL wr_gnt_cycle0: got %b required 0", a_gnt); end
    @(negedge clk);
    tests++;
    if ({a_gnt, b_gnt, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 9'd1, 32'hA5A5A5A5}) begin
      fails++;
      $display("FAIL wr_issue: gnt=%b%b csb=%b web=%b wmask=%b addr=%h din=%h, required 10 0 0 0010 001 a5a5a5a5",
               a_gnt, b_gnt, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0);
    end
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, ram_csb0, a_gnt} !== 3'b010) begin
      fails++; $display("FAIL wr_done: busy/csb/gnt=%b required 010", {busy, ram_csb0, a_gnt});
    end
    @(posedge clk); #1;
    a_we = 1'b0; a_req = 1'b1; exp_a.push_back(ref_mem[5]);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({a_gnt, ram_csb0, ram_web0, ram_wmask0, ram_din0} !== {1'b1, 1'b0, 1'b1, 4'b0000, 32'hA5A5A5A5}) begin
      fails++;
      $display("FAIL rd_issue: gnt=%b csb=%b web=%b wmask=%b din=%h, required 1 0 1 0000 a5a5a5a5",
               a_gnt, ram_csb0, ram_web0, ram_wmask0, ram_din0);
    end
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_rvalid, busy, ram_csb0} !== 3'b011) begin
      fails++; $display("FAIL rd_wait: rvalid/busy/csb=%b required 011", {a_rvalid, busy, ram_csb0});
    end
    @(negedge clk);
    tests++;
    if ({a_rvalid, b_rvalid, rdata} !== {1'b1, 1'b0, 8'hA5}) begin
      fails++; $display("FAIL rd_cycle3: rvalid=%b%b rdata=%h required 10 a5", a_rvalid, b_rvalid, rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_lanes();
    logic [7:0] dat [4];
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 11'(12 + i), dat[i]);
    drain();
    tests++;
    if (mem[3] !== 32'h44332211) begin fails++; $display("FAIL lane_word3: got %h required 44332211", mem[3]); end
    for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 11'(12 + i), 8'h00);
    drain();
  endtask

  task automatic test_arbitration();
    bit order [6];
    order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0; order[3] = 1'b1; order[4] = 1'b0; order[5] = 1'b1;
    apply_reset();
    gnt_log.delete();
    fork
      begin
        access(1'b0, 1'b1, 11'h020, 8'h31);
        access(1'b0, 1'b0, 11'h020, 8'h00);
        access(1'b0, 1'b1, 11'h021, 8'h32);
      end
      begin
        access(1'b1, 1'b1, 11'h042, 8'h41);
        access(1'b1, 1'b0, 11'h042, 8'h00);
        access(1'b1, 1'b1, 11'h043, 8'h42);
      end
    join
    drain();
    tests++;
    if (gnt_log.size() != 6) begin
      fails++; $display("FAIL arb_count: got %0d grants required 6", gnt_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (gnt_log[i] !== order[i]) begin
          fails++; $display("FAIL arb_order[%0d]: got %s required %s", i, gnt_log[i] ? "B" : "A", order[i] ? "B" : "A");
        end
      end
    end
    apply_reset();
    gnt_log.delete();
    access(1'b1, 1'b0, 11'h043, 8'h00);
    drain();
    tests++;
    if (gnt_log.size() != 1 || gnt_log[0] !== 1'b1) begin
      fails++; $display("FAIL arb_b_alone: got %0d grants first=%b, required one grant to B", gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'b0);
    end
  endtask

  task automatic test_ena();
    ena = 1'b0;
    a_we = 1'b1; a_addr = 11'h100; a_wdata = 8'h77; a_req = 1'b1; ref_mem[11'h100] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({a_gnt, b_gnt, ram_csb0, busy} !== 4'b0010) begin
        fails++; $display("FAIL ena_gated[%0d]: gnt=%b%b csb=%b busy=%b required 00 1 0", i, a_gnt, b_gnt, ram_csb0, busy);
      end
    end
    @(posedge clk); #1;
    ena = 1'b1;
    @(negedge clk);
    tests++;
    if (a_gnt !== 1'b0) begin fails++; $display("FAIL ena_early_gnt: got %b required 0", a_gnt); end
    @(negedge clk);
    tests++;
    if (a_gnt !== 1'b1) begin fails++; $display("FAIL ena_gnt: got %b required 1", a_gnt); end
    @(posedge clk); #1;
    a_req = 1'b0;
    drain();
    a_we = 1'b0;
    access(1'b0, 1'b0, 11'h100, 8'h00);
    drain();
  endtask

  task automatic test_reset_mid_read();
    a_we = 1'b0; a_addr = 11'h005; a_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (a_gnt !== 1'b1) begin fails++; $display("FAIL rst_rd_gnt: got %b required 1", a_gnt); end
    @(posedge clk); #1;
    a_req = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rst_rd_busy_before: got %b required 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({ram_csb0, busy, a_gnt, a_rvalid} !== 4'b1000) begin
      fails++; $display("FAIL rst_async: csb/busy/gnt/rvalid=%b required 1000", {ram_csb0, busy, a_gnt, a_rvalid});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (a_rvalid !== 1'b0) begin fails++; $display("FAIL rst_no_rvalid[%0d]: got %b required 0", i, a_rvalid); end
    end
    @(posedge clk); #1;
    gnt_log.delete();
    fork
      access(1'b0, 1'b1, 11'h200, 8'h5A);
      access(1'b1, 1'b1, 11'h204, 8'hC3);
    join
    drain();
    tests++;
    if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0) begin
      fails++; $display("FAIL rst_first_winner: got %0d grants first=%b, required A first", gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'b1);
    end
  endtask

  task automatic test_param_latency();
    logic [31:0] words [7];
    bit          rv_exp [7];
    words[0] = 32'hDEADBEEF; words[1] = 32'hDEADBEEF; words[2] = 32'h11111111; words[3] = 32'h22222222;
    words[4] = 32'hA1B2C3D4; words[5] = 32'h55555555; words[6] = 32'h66666666;
    for (int i = 0; i < 7; i++) rv_exp[i] = (i == 5);
    c_we = 1'b0; c_addr = 11'h007; c_req = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc == 2) c_req = 1'b0;
      c_dout = words[cyc];
      @(negedge clk);
      if (cyc == 1) begin
        tests++;
        if (c_gnt !== 1'b1) begin fails++; $display("FAIL w3_gnt: got %b required 1", c_gnt); end
      end
      tests++;
      if (c_rvalid !== rv_exp[cyc]) begin
        fails++; $display("FAIL w3_rvalid_cycle%0d: got %b required %b", cyc, c_rvalid, rv_exp[cyc]);
      end
      if (cyc >= 5) begin
        tests++;
        if (c_rdata !== 8'hA1) begin fails++; $display("FAIL w3_rdata_cycle%0d: got %h required a1", cyc, c_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_arbitration();
    test_ena();
    test_reset_mid_read();
    test_param_latency();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
